// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage arithmetic unit.
//   Single-cycle ALU ops (add/sub, logic, compare, shifts, HI/LO moves) and an
//   iterative multiply/divide engine (one bit per cycle) with HI/LO registers.
//
// Handshake: a request is accepted on a rising edge where start=1 and the
//   engine is IDLE. Requests while busy=1 are dropped, not queued. Every
//   accepted request produces exactly one done pulse. result/ovf/divz are
//   valid in the done cycle and hold until the next completion.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start, op        issue request and 5-bit operation code
//   a, b, shamt      operands (rs, rt) and immediate shift amount
//   busy             multiply/divide iteration in progress
//   done             one-cycle completion pulse
//   result           registered result
//   ovf, divz        signed overflow (ADD/SUB), divide by zero
//   hi, lo           architectural HI/LO registers
//   dbg_state        current engine state (0 IDLE, 1 MUL, 2 DIV)
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SW-1:0]    shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             divz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_ADDU  = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SUBU  = 5'd3;
    localparam logic [4:0] OP_AND   = 5'd4;
    localparam logic [4:0] OP_OR    = 5'd5;
    localparam logic [4:0] OP_XOR   = 5'd6;
    localparam logic [4:0] OP_NOR   = 5'd7;
    localparam logic [4:0] OP_SLT   = 5'd8;
    localparam logic [4:0] OP_SLTU  = 5'd9;
    localparam logic [4:0] OP_SLL   = 5'd10;
    localparam logic [4:0] OP_SRL   = 5'd11;
    localparam logic [4:0] OP_SRA   = 5'd12;
    localparam logic [4:0] OP_SLLV  = 5'd13;
    localparam logic [4:0] OP_SRLV  = 5'd14;
    localparam logic [4:0] OP_SRAV  = 5'd15;
    localparam logic [4:0] OP_MULT  = 5'd16;
    localparam logic [4:0] OP_MULTU = 5'd17;
    localparam logic [4:0] OP_DIV   = 5'd18;
    localparam logic [4:0] OP_DIVU  = 5'd19;
    localparam logic [4:0] OP_MFHI  = 5'd20;
    localparam logic [4:0] OP_MFLO  = 5'd21;
    localparam logic [4:0] OP_MTHI  = 5'd22;
    localparam logic [4:0] OP_MTLO  = 5'd23;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    // Shared work register: {acc, multiplier} for MUL, {rem, quotient} for DIV.
    logic [2*WIDTH-1:0] work_q, work_d;
    // Latched multiplicand (MUL) or divisor (DIV) magnitude.
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               divz_q, divz_d;

    // ---------------- single-cycle ALU ----------------
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ovf;
    logic [SW-1:0]    vamt;

    assign sum  = a + b;
    assign diff = a - b;
    assign vamt = a[SW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU: alu_res = diff;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_res = b << shamt;
            OP_SRL:  alu_res = b >> shamt;
            OP_SRA:  alu_res = $signed(b) >>> shamt;
            OP_SLLV: alu_res = b << vamt;
            OP_SRLV: alu_res = b >> vamt;
            OP_SRAV: alu_res = $signed(b) >>> vamt;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;   // MTHI/MTLO and illegal codes
        endcase
    end

    // ---------------- iterative engine datapath ----------------
    // Signed ops run on magnitudes; the sign is restored at completion.
    // |MIN| is MIN reinterpreted as unsigned, which is exactly right here.
    logic             signed_md;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign signed_md = (op == OP_MULT) || (op == OP_DIV);
    assign a_mag     = (signed_md && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_md && b[WIDTH-1]) ? -b : b;

    // Shift-add step: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole register right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_fin;

    assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                    + {1'b0, (work_q[0] ? opd_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, work_q[WIDTH-1:1]};
    assign mul_fin  = neg_res_q ? -mul_next : mul_next;

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. The remainder is always < divisor,
    // so the difference fits in WIDTH bits.
    logic [WIDTH:0]     div_tmp;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub, rem_next;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_fin, rem_fin;

    assign div_tmp  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    assign div_ge   = div_tmp >= {1'b0, opd_q};
    assign div_sub  = div_tmp[WIDTH-1:0] - opd_q;
    assign rem_next = div_ge ? div_sub : div_tmp[WIDTH-1:0];
    assign div_next = {rem_next, work_q[WIDTH-2:0], div_ge};
    assign quo_fin  = neg_res_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    assign rem_fin  = neg_rem_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];

    // ---------------- next-state / output logic ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        opd_d     = opd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        divz_d    = divz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d   = S_MUL;
                            cnt_d     = '0;
                            work_d    = {{WIDTH{1'b0}}, b_mag};
                            opd_d     = a_mag;
                            neg_res_d = signed_md && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem_d = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b == '0) begin
                                // Divide by zero completes immediately.
                                done_d   = 1'b1;
                                divz_d   = 1'b1;
                                ovf_d    = 1'b0;
                                hi_d     = a;
                                lo_d     = '1;
                                result_d = '1;
                            end else begin
                                state_d   = S_DIV;
                                cnt_d     = '0;
                                work_d    = {{WIDTH{1'b0}}, a_mag};
                                opd_d     = b_mag;
                                neg_res_d = signed_md && (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_rem_d = signed_md && a[WIDTH-1];
                            end
                        end
                        default: begin
                            done_d   = 1'b1;
                            divz_d   = 1'b0;
                            ovf_d    = alu_ovf;
                            result_d = alu_res;
                            if (op == OP_MTHI) hi_d = a;
                            if (op == OP_MTLO) lo_d = a;
                        end
                    endcase
                end
            end
            S_MUL: begin
                work_d = mul_next;
                if (cnt_q == SW'(WIDTH-1)) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    ovf_d    = 1'b0;
                    divz_d   = 1'b0;
                    hi_d     = mul_fin[2*WIDTH-1:WIDTH];
                    lo_d     = mul_fin[WIDTH-1:0];
                    result_d = mul_fin[WIDTH-1:0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV: begin
                work_d = div_next;
                if (cnt_q == SW'(WIDTH-1)) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    ovf_d    = 1'b0;
                    divz_d   = 1'b0;
                    hi_d     = rem_fin;
                    lo_d     = quo_fin;
                    result_d = quo_fin;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            opd_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            divz_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            opd_q     <= opd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            divz_q    <= divz_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign divz      = divz_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [4:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [4:0]   shamt;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         ovf;
  logic         divz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   dbg_state;

  alu_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .shamt(shamt), .busy(busy), .done(done), .result(result), .ovf(ovf),
    .divz(divz), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   sh;
    logic [W-1:0] res;
    logic         ovf;
  } vec_t;

  vec_t vecs[$];

  // scoreboard entries are {divz, ovf, result}
  logic [W+1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(input logic [4:0] o, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic [4:0] s,
                              input logic [W-1:0] r, input logic v);
    vec_t t;
    t.op = o; t.a = x; t.b = y; t.sh = s; t.res = r; t.ovf = v;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance one cycle; the scoreboard consumes any done pulse seen.
  task automatic tick();
    logic [W+1:0] e;
    @(negedge clk);
    if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done actual=%h required=no_done", result);
      end else begin
        e = exp_q.pop_front();
        if ({divz, ovf, result} !== e) begin
          errors++;
          $display("FAIL sb_done actual={divz,ovf,result}=%h required=%h", {divz, ovf, result}, e);
        end
      end
    end
  endtask

  task automatic drive(input logic [4:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [4:0] s);
    start = 1'b1; op = o; a = x; b = y; shamt = s;
  endtask

  // Issue a multi-cycle (or divide-by-zero) op and wait for its done.
  task automatic run_md(input string name, input logic [4:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input logic edivz, input int ebusy);
    int  bcnt;
    logic got;
    bcnt = 0; got = 1'b0;
    exp_q.push_back({edivz, 1'b0, elo});
    drive(o, x, y, 5'd0);
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom;   // operands must already be latched
    for (int i = 0; i < 200; i++) begin
      if (done) begin got = 1'b1; break; end
      if (busy) bcnt++;
      tick();
    end
    chk({name, "_done_seen"}, 64'(got), 64'd1);
    chk({name, "_busy_cycles"}, 64'(bcnt), 64'(ebusy));
    chk({name, "_hi"}, 64'(hi), 64'(ehi));
    chk({name, "_lo"}, 64'(lo), 64'(elo));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int bcnt;
    logic got;
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; shamt = '0;

    // reset state
    repeat (3) tick();
    chk("rst_outputs", {busy, done, ovf, divz, dbg_state, result},
        {4'b0000, 2'b00, 32'h0});
    chk("rst_hilo", {hi, lo}, 64'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy_done", {62'h0, busy, done}, 64'h0);

    // single-cycle vectors
    vecs.push_back(mk(5'd0,  32'h7FFF_FFFF, 32'h1,         5'd0,  32'h8000_0000, 1'b1));
    vecs.push_back(mk(5'd8,  32'hFFFF_FFFF, 32'h1,         5'd0,  32'h1,         1'b0));
    vecs.push_back(mk(5'd9,  32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         1'b0));
    vecs.push_back(mk(5'd12, 32'h0,         32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0));
    vecs.push_back(mk(5'd14, 32'd36,        32'hF0,        5'd0,  32'h0F,        1'b0));
    vecs.push_back(mk(5'd2,  32'h8000_0000, 32'h1,         5'd0,  32'h7FFF_FFFF, 1'b1));
    vecs.push_back(mk(5'd3,  32'h0,         32'h1,         5'd0,  32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(5'd1,  32'h7FFF_FFFF, 32'h1,         5'd0,  32'h8000_0000, 1'b0));
    vecs.push_back(mk(5'd0,  32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         1'b0));
    vecs.push_back(mk(5'd4,  32'hF0F0,      32'hFF00,      5'd0,  32'hF000,      1'b0));
    vecs.push_back(mk(5'd5,  32'hF0F0,      32'hFF00,      5'd0,  32'hFFF0,      1'b0));
    vecs.push_back(mk(5'd6,  32'hF0F0,      32'hFF00,      5'd0,  32'h0FF0,      1'b0));
    vecs.push_back(mk(5'd7,  32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(5'd10, 32'h0,         32'h1,         5'd31, 32'h8000_0000, 1'b0));
    vecs.push_back(mk(5'd11, 32'h0,         32'h8000_0000, 5'd31, 32'h1,         1'b0));
    vecs.push_back(mk(5'd13, 32'd33,        32'h3,         5'd0,  32'h6,         1'b0));
    vecs.push_back(mk(5'd15, 32'h1,         32'h8000_0000, 5'd7,  32'hC000_0000, 1'b0));
    vecs.push_back(mk(5'd25, 32'h1234,      32'h5678,      5'd0,  32'h0,         1'b0));
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      case (i % 3)
        0: vecs.push_back(mk(5'd1, ra, rb, 5'd0, ra + rb, 1'b0));
        1: vecs.push_back(mk(5'd6, ra, rb, 5'd0, ra ^ rb, 1'b0));
        default: vecs.push_back(mk(5'd9, ra, rb, 5'd0, (ra < rb) ? 32'h1 : 32'h0, 1'b0));
      endcase
    end

    // start held high across consecutive cycles: one done per cycle
    foreach (vecs[i]) begin
      exp_q.push_back({1'b0, vecs[i].ovf, vecs[i].res});
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
      tick();
    end
    start = 1'b0;
    chk("alu_stream_drained", 64'(exp_q.size()), 64'd0);
    chk("illegal_hilo_unchanged", {hi, lo}, 64'h0);
    tick();

    // multiply / divide
    run_md("mult_m3x7", 5'd16, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 32);
    run_md("multu_max", 5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0, 32);
    exp_q.push_back({2'b00, 32'hFFFF_FFFE});   // MFHI back-to-back in done cycle
    drive(5'd20, 32'h0, 32'h0, 5'd0);
    tick();
    start = 1'b0;
    chk("mfhi_after_mult_drained", 64'(exp_q.size()), 64'd0);
    run_md("div_m7_2", 5'd18, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 32);
    run_md("divu_100_7", 5'd19, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 32);
    run_md("div_min_m1", 5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 32);
    run_md("divu_by0", 5'd19, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 0);
    tick();

    // handshake: ADD held high during a DIVU is accepted only in its done cycle
    exp_q.push_back({2'b00, 32'd14});
    exp_q.push_back({2'b00, 32'd7});
    drive(5'd19, 32'd100, 32'd7, 5'd0);
    tick();
    drive(5'd0, 32'd3, 32'd4, 5'd0);
    bcnt = 0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin got = 1'b1; break; end
      if (busy) bcnt++;
      tick();
    end
    chk("hs_div_done_seen", 64'(got), 64'd1);
    chk("hs_div_busy_cycles", 64'(bcnt), 64'd32);
    tick();
    start = 1'b0;
    chk("hs_add_done_next", {63'h0, done}, 64'd1);
    tick();
    chk("hs_done_pulse_low", {63'h0, done}, 64'd0);
    chk("hs_drained", 64'(exp_q.size()), 64'd0);

    // MTHI then MFHI
    exp_q.push_back({2'b00, 32'h0});
    exp_q.push_back({2'b00, 32'h1234});
    drive(5'd22, 32'h1234, 32'h0, 5'd0);
    tick();
    drive(5'd20, 32'h0, 32'h0, 5'd0);
    tick();
    start = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234);
    tick();

    // reset in the middle of MULTU 0xFFFF_FFFF x 2
    drive(5'd17, 32'hFFFF_FFFF, 32'd2, 5'd0);
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("midop_busy_before_rst", {63'h0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midop_rst_flags", {59'h0, busy, done, ovf, divz, 1'b0}, 64'h0);
    chk("midop_rst_result", 64'(result), 64'h0);
    chk("midop_rst_hilo", {hi, lo}, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back({2'b00, 32'd2});
    drive(5'd1, 32'd1, 32'd1, 5'd0);
    tick();
    start = 1'b0;
    repeat (40) tick();   // the discarded multiply must never complete
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("final_idle", {62'h0, dbg_state}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
